// File: rtl/io_map_pkg.sv
// Memory-map constants and address-decode helper shared by the IO controller
// and its testbench-facing top.
package io_map_pkg;

  localparam int unsigned IO_BASE_BIT      = 8;
  localparam int unsigned LEDS_BIT         = 2;
  localparam int unsigned HEX_BIT          = 3;
  localparam int unsigned KEY_BIT          = 4;
  localparam int unsigned SW_BIT           = 5;
  localparam int unsigned KEY_EVT_BIT      = 6;
  localparam int unsigned NUM_KEYS         = 4;
  localparam int unsigned NUM_SW           = 10;
  localparam int unsigned DEBOUNCE_DEFAULT = 3;

  typedef struct packed {
    logic leds;
    logic hex;
    logic key;
    logic sw;
    logic key_evt;
  } io_sel_t;

  function automatic io_sel_t decode_sel(input logic [31:0] a);
    io_sel_t s;
    s.leds    = a[LEDS_BIT];
    s.hex     = a[HEX_BIT];
    s.key     = a[KEY_BIT];
    s.sw      = a[SW_BIT];
    s.key_evt = a[KEY_EVT_BIT];
    return s;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer, consecutive-cycle counter and the
// accepted (stable) level. press_o pulses on the edge stable falls 1->0.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw_i,
  output logic key_stable_o,
  output logic press_o
);

  localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);

  logic       meta_q;
  logic       sync_q;
  logic       stable_q;
  logic       stable_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic [7:0] cnt_inc_s;

  // Next-state: accept the synchronized level once it has differed long enough.
  always_comb begin
    cnt_inc_s = cnt_q + 8'd1;
    stable_d  = stable_q;
    press_o   = 1'b0;
    cnt_d     = 8'd0;
    if (sync_q != stable_q) begin
      if (cnt_inc_s == DB_LIMIT) begin
        stable_d = sync_q;
        cnt_d    = 8'd0;
        press_o  = stable_q & ~sync_q;
      end else begin
        cnt_d = cnt_inc_s;
      end
    end else begin
      cnt_d = 8'd0;
    end
  end

  // Synchronizer, counter and stable-level registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q   <= 1'b1;
      sync_q   <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= 8'd0;
    end else begin
      meta_q   <= key_raw_i;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign key_stable_o = stable_q;

endmodule

// File: rtl/io_controller.sv
// Memory-mapped IO block: RAM/IO decode, LED and HEX registers, synchronized
// switches, debounced keys with sticky write-1-to-clear press events.
module io_controller
  import io_map_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         addr,
  input  logic [31:0]         writedata,
  input  logic                memwrite,
  input  logic [31:0]         mem_readdata,
  output logic                ram_we,
  output logic [31:0]         readdata,
  input  logic [NUM_KEYS-1:0] KEY,
  input  logic [NUM_SW-1:0]   SW,
  output logic [NUM_SW-1:0]   LEDR,
  output logic [23:0]         hex_digits
);

  io_sel_t             sel_s;
  logic                is_io_s;
  logic                io_wr_s;
  logic [NUM_KEYS-1:0] key_stable_s;
  logic [NUM_KEYS-1:0] press_s;
  logic [NUM_KEYS-1:0] evt_clr_s;
  logic [NUM_KEYS-1:0] evt_q;
  logic [NUM_KEYS-1:0] evt_d;
  logic [NUM_SW-1:0]   led_q;
  logic [NUM_SW-1:0]   led_d;
  logic [23:0]         hex_q;
  logic [23:0]         hex_d;
  logic [NUM_SW-1:0]   sw_meta_q;
  logic [NUM_SW-1:0]   sw_sync_q;
  logic                unused_s;

  assign sel_s    = decode_sel(addr);
  assign is_io_s  = addr[IO_BASE_BIT];
  assign io_wr_s  = memwrite & is_io_s;
  assign ram_we   = memwrite & ~is_io_s;
  assign unused_s = ^{addr[31:9], addr[7], addr[1:0], writedata[31:24]};

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_debounce (
      .clk          (clk),
      .reset        (reset),
      .key_raw_i    (KEY[i]),
      .key_stable_o (key_stable_s[i]),
      .press_o      (press_s[i])
    );
  end

  // Register next-state; a press landing with a W1C on the same bit wins.
  always_comb begin
    led_d     = led_q;
    hex_d     = hex_q;
    evt_clr_s = 4'd0;
    if (io_wr_s) begin
      if (sel_s.leds) begin
        led_d = writedata[9:0];
      end else begin
        led_d = led_q;
      end
      if (sel_s.hex) begin
        hex_d = writedata[23:0];
      end else begin
        hex_d = hex_q;
      end
      if (sel_s.key_evt) begin
        evt_clr_s = writedata[3:0];
      end else begin
        evt_clr_s = 4'd0;
      end
    end else begin
      evt_clr_s = 4'd0;
    end
    evt_d = (evt_q & ~evt_clr_s) | press_s;
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q     <= 10'd0;
      hex_q     <= 24'd0;
      evt_q     <= 4'd0;
      sw_meta_q <= 10'd0;
      sw_sync_q <= 10'd0;
    end else begin
      led_q     <= led_d;
      hex_q     <= hex_d;
      evt_q     <= evt_d;
      sw_meta_q <= SW;
      sw_sync_q <= sw_meta_q;
    end
  end

  // CPU read mux with fixed IO priority.
  always_comb begin
    if (!is_io_s) begin
      readdata = mem_readdata;
    end else if (sel_s.key) begin
      readdata = {28'd0, key_stable_s};
    end else if (sel_s.sw) begin
      readdata = {22'd0, sw_sync_q};
    end else if (sel_s.key_evt) begin
      readdata = {28'd0, evt_q};
    end else if (sel_s.leds) begin
      readdata = {22'd0, led_q};
    end else if (sel_s.hex) begin
      readdata = {8'd0, hex_q};
    end else begin
      readdata = 32'd0;
    end
  end

  assign LEDR       = led_q;
  assign hex_digits = hex_q;

endmodule

// File: tb/tb_io_controller.sv
// Directed and randomized checks of io_controller against a windowed
// behavioural model of the key, switch and register behaviour.
module tb_io_controller;

  localparam int DB = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic        memwrite;
  logic [31:0] mem_readdata;
  logic        ram_we;
  logic [31:0] readdata;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [9:0]  LEDR;
  logic [23:0] hex_digits;

  int checks = 0;
  int errors = 0;

  // model state: khist[0] is the raw key sample of the previous edge, khist[k] k edges older
  logic [9:0]  m_led;
  logic [23:0] m_hex;
  logic [3:0]  m_evt;
  logic [3:0]  m_stable;
  logic [3:0]  khist [0:DB];
  logic [9:0]  swh0;
  logic [9:0]  swh1;
  logic [31:0] addr_list [0:8];
  int          run [0:3];

  io_controller #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .writedata    (writedata),
    .memwrite     (memwrite),
    .mem_readdata (mem_readdata),
    .ram_we       (ram_we),
    .readdata     (readdata),
    .KEY          (KEY),
    .SW           (SW),
    .LEDR         (LEDR),
    .hex_digits   (hex_digits)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_led    = 10'd0;
    m_hex    = 24'd0;
    m_evt    = 4'd0;
    m_stable = 4'hF;
    for (int k = 0; k <= DB; k++) khist[k] = 4'hF;
    swh0 = 10'd0;
    swh1 = 10'd0;
  endtask

  // A key level is accepted once DB consecutive synchronized samples
  // (raw samples 2..DB+1 edges old) all differ from the accepted level.
  task automatic tick();
    logic [3:0] press;
    logic [3:0] nstable;
    logic [3:0] clr;
    logic       accept;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      press   = 4'd0;
      nstable = m_stable;
      clr     = 4'd0;
      for (int i = 0; i < 4; i++) begin
        accept = 1'b1;
        for (int k = 1; k <= DB; k++) if (khist[k][i] == m_stable[i]) accept = 1'b0;
        if (accept) begin
          nstable[i] = ~m_stable[i];
          if (m_stable[i]) press[i] = 1'b1;
        end
      end
      if (memwrite && addr[8]) begin
        if (addr[2]) m_led = writedata[9:0];
        if (addr[3]) m_hex = writedata[23:0];
        if (addr[6]) clr = writedata[3:0];
      end
      m_evt    = (m_evt & ~clr) | press;
      m_stable = nstable;
      for (int k = DB; k > 0; k--) khist[k] = khist[k-1];
      khist[0] = KEY;
      swh1 = swh0;
      swh0 = SW;
    end
    #1;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [31:0] mrd);
    if (!a[8]) return mrd;
    if (a[4])  return {28'd0, m_stable};
    if (a[5])  return {22'd0, swh1};
    if (a[6])  return {28'd0, m_evt};
    if (a[2])  return {22'd0, m_led};
    if (a[3])  return {8'd0, m_hex};
    return 32'd0;
  endfunction

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr     = a;
    memwrite = 1'b0;
    #1;
    check(tag, readdata, exp);
  endtask

  task automatic write_io(input logic [31:0] a, input logic [31:0] d);
    addr      = a;
    writedata = d;
    memwrite  = 1'b1;
    tick();
    memwrite  = 1'b0;
  endtask

  initial begin
    addr_list[0] = 32'h104; addr_list[1] = 32'h108; addr_list[2] = 32'h110;
    addr_list[3] = 32'h120; addr_list[4] = 32'h140; addr_list[5] = 32'h14C;
    addr_list[6] = 32'h100; addr_list[7] = 32'h040; addr_list[8] = 32'h17C;
    for (int i = 0; i < 4; i++) run[i] = 0;

    reset = 1'b1; addr = 32'd0; writedata = 32'd0; memwrite = 1'b0;
    mem_readdata = 32'h1234_5678; KEY = 4'hF; SW = 10'h155;
    model_reset();
    tick(); tick();
    check("rst_ledr", {22'd0, LEDR}, 32'd0);
    check("rst_hex", {8'd0, hex_digits}, 32'd0);
    rd("rst_key", 32'h110, 32'hF);
    rd("rst_sw", 32'h120, 32'h0);
    rd("rst_evt", 32'h140, 32'h0);
    addr = 32'h040; memwrite = 1'b1; #1;
    check("rst_ram_we", {31'd0, ram_we}, 32'd1);
    memwrite = 1'b0;
    reset = 1'b0;

    addr = 32'h104; writedata = 32'h3FF; memwrite = 1'b1; #1;
    check("led_ram_we", {31'd0, ram_we}, 32'd0);
    tick(); memwrite = 1'b0;
    check("led_val", {22'd0, LEDR}, 32'h3FF);
    rd("led_read", 32'h104, 32'h3FF);
    write_io(32'h108, 32'h00AB_CDEF);
    check("hex_val", {8'd0, hex_digits}, 32'hABCDEF);
    addr = 32'h040; writedata = 32'hFFFF_FFFF; memwrite = 1'b1; #1;
    check("ram_we_ram", {31'd0, ram_we}, 32'd1);
    tick(); memwrite = 1'b0;
    check("ram_led_keep", {22'd0, LEDR}, 32'h3FF);
    check("ram_hex_keep", {8'd0, hex_digits}, 32'hABCDEF);
    rd("sw_sync", 32'h120, 32'h155);
    rd("ram_read", 32'h040, 32'h1234_5678);

    KEY = 4'hD;
    repeat (4) tick();
    rd("key1_early", 32'h110, 32'hF);
    tick();
    rd("key1_stable", 32'h110, 32'hD);
    rd("key1_evt", 32'h140, 32'h2);
    KEY = 4'hF;
    repeat (5) tick();
    rd("key1_release", 32'h110, 32'hF);
    rd("release_no_evt", 32'h140, 32'h2);

    KEY = 4'hE; tick(); tick(); KEY = 4'hF;
    for (int c = 0; c < 6; c++) begin
      tick();
      rd("glitch_key", 32'h110, 32'hF);
    end
    rd("glitch_evt", 32'h140, 32'h2);

    KEY = 4'hE; repeat (5) tick();
    rd("key0_evt", 32'h140, 32'h3);
    KEY = 4'hF; repeat (5) tick();
    write_io(32'h140, 32'h1);
    rd("w1c_bit0", 32'h140, 32'h2);

    KEY = 4'hB; repeat (4) tick();
    addr = 32'h140; writedata = 32'h4; memwrite = 1'b1;
    tick(); memwrite = 1'b0;
    rd("set_wins_key", 32'h110, 32'hB);
    rd("set_wins_evt", 32'h140, 32'h6);
    KEY = 4'hF; repeat (5) tick();
    write_io(32'h140, 32'hF);
    rd("w1c_all", 32'h140, 32'h0);

    KEY = 4'h7; repeat (4) tick();
    reset = 1'b1; tick();
    rd("midrst_key", 32'h110, 32'hF);
    rd("midrst_evt", 32'h140, 32'h0);
    reset = 1'b0;
    repeat (4) tick();
    rd("post_rst_key", 32'h110, 32'hF);
    rd("post_rst_evt", 32'h140, 32'h0);
    tick();
    rd("fresh_key", 32'h110, 32'h7);
    rd("fresh_evt", 32'h140, 32'h8);
    KEY = 4'hF; repeat (5) tick();

    for (int c = 0; c < 600; c++) begin
      reset = 1'b0;
      check("rnd_ledr", {22'd0, LEDR}, {22'd0, m_led});
      check("rnd_hex", {8'd0, hex_digits}, {8'd0, m_hex});
      addr = addr_list[$urandom_range(0, 8)];
      memwrite = 1'b0;
      mem_readdata = $urandom;
      #1;
      check("rnd_read", readdata, model_read(addr, mem_readdata));
      addr = addr_list[$urandom_range(0, 8)];
      writedata = $urandom;
      memwrite = 1'($urandom_range(0, 1));
      #1;
      check("rnd_ram_we", {31'd0, ram_we}, {31'd0, memwrite & ~addr[8]});
      for (int i = 0; i < 4; i++) begin
        if (run[i] == 0) begin
          KEY[i] = 1'($urandom_range(0, 1));
          run[i] = int'($urandom_range(1, 6));
        end
        run[i] = run[i] - 1;
      end
      if ($urandom_range(0, 15) == 0) SW = 10'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;
    memwrite = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
